// File: rtl/cmsdk_fpga_param_sram.sv
// Single-port block RAM with byte-lane writes, 1- or 2-cycle read latency and a
// post-reset clear sequencer that fills every word with a fixed byte pattern.
module cmsdk_fpga_param_sram #(
   parameter int unsigned AW       = 16,
   parameter int unsigned DW       = 32,
   parameter int unsigned RD_LAT   = 1,
   parameter bit          INIT_CLR = 1'b1,
   parameter logic [7:0]  INIT_VAL = 8'h00
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [AW-1:0]   ADDR,
   input  logic [DW-1:0]   WDATA,
   input  logic [DW/8-1:0] WREN,
   input  logic            CS,
   output logic [DW-1:0]   RDATA,
   output logic            RVALID,
   output logic            READY,
   output logic            ACC_ERR
);

   localparam int unsigned NL    = DW / 8;
   localparam int unsigned DEPTH = 2 ** AW;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   localparam state_t RST_STATE = INIT_CLR ? CLEAR : RUN;

   if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
      $error("cmsdk_fpga_param_sram: RD_LAT must be 1 or 2");
   end
   if (DW % 8 != 0 || DW == 0) begin : g_bad_dw
      $error("cmsdk_fpga_param_sram: DW must be a non-zero multiple of 8");
   end

   state_t        state_q, state_d;
   logic [AW-1:0] clr_cnt_q, clr_cnt_d;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [NL-1:0] wr_lanes;
   logic          rd_en;
   logic          acc_err_d;

   logic [DW-1:0] mem [DEPTH];

   logic [DW-1:0] rdata1_q;
   logic          rvalid1_q;
   logic          acc_err_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= RST_STATE;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // The clear sequencer and the user port share the single write port.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      wr_addr   = ADDR;
      wr_data   = WDATA;
      wr_lanes  = '0;
      rd_en     = 1'b0;
      acc_err_d = 1'b0;
      case (state_q)
         CLEAR: begin
            clr_cnt_d = clr_cnt_q + AW'(1);
            wr_addr   = clr_cnt_q;
            wr_data   = {NL{INIT_VAL}};
            wr_lanes  = '1;
            acc_err_d = CS;
            if (&clr_cnt_q) state_d = RUN;
         end
         RUN: begin
            if (CS) begin
               wr_lanes = WREN;
               rd_en    = (WREN == '0);
            end
         end
      endcase
   end

   // NOTE: the array has no reset; RST leaves contents alone and the RAM maps onto block RAM.
   always_ff @(posedge CLK) begin
      for (int i = 0; i < NL; i++) begin
         if (wr_lanes[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rdata1_q  <= '0;
         rvalid1_q <= 1'b0;
         acc_err_q <= 1'b0;
      end else begin
         rdata1_q  <= rd_en ? mem[ADDR] : '0;
         rvalid1_q <= rd_en;
         acc_err_q <= acc_err_d;
      end
   end

   if (RD_LAT == 2) begin : g_lat2
      logic [DW-1:0] rdata2_q;
      logic          rvalid2_q;

      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            rdata2_q  <= '0;
            rvalid2_q <= 1'b0;
         end else begin
            rdata2_q  <= rdata1_q;
            rvalid2_q <= rvalid1_q;
         end
      end

      assign RDATA  = rdata2_q;
      assign RVALID = rvalid2_q;
   end else begin : g_lat1
      assign RDATA  = rdata1_q;
      assign RVALID = rvalid1_q;
   end

   assign READY   = (state_q == RUN);
   assign ACC_ERR = acc_err_q;

endmodule

// File: tb/tb_cmsdk_fpga_param_sram.sv
// Directed bench: three SRAM instances (32-bit latency 1, 32-bit latency 2, 64-bit latency 1).
module tb_cmsdk_fpga_param_sram;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n;

   logic        a_rst, a_cs, a_rvalid, a_ready, a_acc_err;
   logic [3:0]  a_addr, a_wren;
   logic [31:0] a_wdata, a_rdata;

   logic        b_rst, b_cs, b_rvalid, b_ready, b_acc_err;
   logic [3:0]  b_addr, b_wren;
   logic [31:0] b_wdata, b_rdata;

   logic        c_rst, c_cs, c_rvalid, c_ready, c_acc_err;
   logic [3:0]  c_addr;
   logic [7:0]  c_wren;
   logic [63:0] c_wdata, c_rdata;

   cmsdk_fpga_param_sram #(.AW(4), .DW(32), .RD_LAT(1), .INIT_CLR(1'b1), .INIT_VAL(8'hA5)) u_a (
      .CLK(clk), .RST(a_rst), .ADDR(a_addr), .WDATA(a_wdata), .WREN(a_wren), .CS(a_cs),
      .RDATA(a_rdata), .RVALID(a_rvalid), .READY(a_ready), .ACC_ERR(a_acc_err)
   );

   cmsdk_fpga_param_sram #(.AW(4), .DW(32), .RD_LAT(2), .INIT_CLR(1'b1), .INIT_VAL(8'hA5)) u_b (
      .CLK(clk), .RST(b_rst), .ADDR(b_addr), .WDATA(b_wdata), .WREN(b_wren), .CS(b_cs),
      .RDATA(b_rdata), .RVALID(b_rvalid), .READY(b_ready), .ACC_ERR(b_acc_err)
   );

   cmsdk_fpga_param_sram #(.AW(4), .DW(64), .RD_LAT(1), .INIT_CLR(1'b1), .INIT_VAL(8'h00)) u_c (
      .CLK(clk), .RST(c_rst), .ADDR(c_addr), .WDATA(c_wdata), .WREN(c_wren), .CS(c_cs),
      .RDATA(c_rdata), .RVALID(c_rvalid), .READY(c_ready), .ACC_ERR(c_acc_err)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      a_rst = 1'b1; a_cs = 1'b0; a_addr = '0; a_wren = '0; a_wdata = '0;
      b_rst = 1'b1; b_cs = 1'b0; b_addr = '0; b_wren = '0; b_wdata = '0;
      c_rst = 1'b1; c_cs = 1'b0; c_addr = '0; c_wren = '0; c_wdata = '0;
      repeat (2) tick;

      check("a_rst_ready",   a_ready,   1'b0);
      check("a_rst_rvalid",  a_rvalid,  1'b0);
      check("a_rst_rdata",   a_rdata,   32'h0);
      check("a_rst_acc_err", a_acc_err, 1'b0);
      check("b_rst_ready",   b_ready,   1'b0);
      check("c_rst_ready",   c_ready,   1'b0);

      // Instance A: clear timing with a dropped write during CLEAR
      a_rst = 1'b0;
      n = 0;
      while (!a_ready && n < 40) begin
         if (n == 3) begin
            a_cs = 1'b1; a_wren = 4'hF; a_addr = 4'd0; a_wdata = 32'hDEADBEEF;
         end else begin
            a_cs = 1'b0; a_wren = 4'h0;
         end
         tick;
         n++;
         if (n == 4) begin
            check("a_acc_err_pulse",  a_acc_err, 1'b1);
            check("a_clear_no_rvalid", a_rvalid, 1'b0);
         end
         if (n == 5) check("a_acc_err_single", a_acc_err, 1'b0);
      end
      a_cs = 1'b0; a_wren = 4'h0;
      check("a_ready_cycles", n, 16);

      for (int i = 0; i < 16; i++) begin
         a_cs = 1'b1; a_wren = 4'h0; a_addr = 4'(i);
         tick;
         check($sformatf("a_clr_rvalid[%0d]", i), a_rvalid, 1'b1);
         check($sformatf("a_clr_rdata[%0d]", i),  a_rdata,  32'hA5A5A5A5);
      end
      a_cs = 1'b0;
      tick;
      check("a_idle_rvalid", a_rvalid, 1'b0);
      check("a_idle_rdata",  a_rdata,  32'h0);

      a_cs = 1'b1; a_addr = 4'd3; a_wdata = 32'h11223344; a_wren = 4'hF;
      tick;
      check("a_wr_rvalid", a_rvalid, 1'b0);
      check("a_wr_rdata",  a_rdata,  32'h0);
      a_wdata = 32'hFFFFFFFF; a_wren = 4'b0101;
      tick;
      a_wren = 4'h0;
      tick;
      check("a_lane_rvalid", a_rvalid, 1'b1);
      check("a_lane_rdata",  a_rdata,  32'h11FF33FF);
      a_addr = 4'd2;
      tick;
      check("a_other_word", a_rdata, 32'hA5A5A5A5);
      a_cs = 1'b0;
      tick;

      // Instance B: reset at clear count 7 restarts the whole clear
      b_rst = 1'b0;
      repeat (7) tick;
      check("b_mid_clear_ready", b_ready, 1'b0);
      #2 b_rst = 1'b1;
      #1;
      check("b_async_rst_ready",  b_ready,  1'b0);
      check("b_async_rst_rvalid", b_rvalid, 1'b0);
      tick;
      b_rst = 1'b0;
      n = 0;
      while (!b_ready && n < 40) begin
         tick;
         n++;
      end
      check("b_ready_cycles", n, 16);

      for (int i = 0; i < 18; i++) begin
         b_wren = 4'h0;
         if (i < 16) begin
            b_cs = 1'b1; b_addr = 4'(i);
         end else begin
            b_cs = 1'b0;
         end
         tick;
         if (i >= 1 && i <= 16) begin
            check($sformatf("b_clr_rvalid[%0d]", i - 1), b_rvalid, 1'b1);
            check($sformatf("b_clr_rdata[%0d]", i - 1),  b_rdata,  32'hA5A5A5A5);
         end else begin
            check($sformatf("b_clr_gap_rvalid[%0d]", i), b_rvalid, 1'b0);
            check($sformatf("b_clr_gap_rdata[%0d]", i),  b_rdata,  32'h0);
         end
      end

      b_cs = 1'b1; b_wren = 4'hF;
      b_addr = 4'd1; b_wdata = 32'h00001111; tick;
      b_addr = 4'd2; b_wdata = 32'h00002222; tick;
      b_addr = 4'd3; b_wdata = 32'h00003333; tick;
      b_cs = 1'b0; b_wren = 4'h0;
      repeat (2) tick;

      b_cs = 1'b1; b_addr = 4'd1;
      tick;
      check("b_lat2_n1_rvalid", b_rvalid, 1'b0);
      check("b_lat2_n1_rdata",  b_rdata,  32'h0);
      b_addr = 4'd2;
      tick;
      check("b_lat2_rd1_rvalid", b_rvalid, 1'b1);
      check("b_lat2_rd1_rdata",  b_rdata,  32'h00001111);
      b_addr = 4'd3;
      tick;
      check("b_lat2_rd2_rvalid", b_rvalid, 1'b1);
      check("b_lat2_rd2_rdata",  b_rdata,  32'h00002222);
      b_cs = 1'b0;
      tick;
      check("b_lat2_rd3_rvalid", b_rvalid, 1'b1);
      check("b_lat2_rd3_rdata",  b_rdata,  32'h00003333);
      tick;
      check("b_lat2_end_rvalid", b_rvalid, 1'b0);
      check("b_lat2_end_rdata",  b_rdata,  32'h0);

      // Instance C: 64-bit word, top-lane-only write
      c_rst = 1'b0;
      n = 0;
      while (!c_ready && n < 40) begin
         tick;
         n++;
      end
      check("c_ready_cycles", n, 16);

      c_cs = 1'b1; c_addr = 4'd5; c_wdata = 64'h0123456789ABCDEF; c_wren = 8'hFF;
      tick;
      c_wren = 8'h00;
      tick;
      check("c_raw_rvalid", c_rvalid, 1'b1);
      check("c_raw_rdata",  c_rdata,  64'h0123456789ABCDEF);
      c_wdata = 64'hFFFFFFFFFFFFFFFF; c_wren = 8'h80;
      tick;
      c_wren = 8'h00;
      tick;
      check("c_top_lane_rdata", c_rdata, 64'hFF23456789ABCDEF);
      c_addr = 4'd4;
      tick;
      check("c_init_rvalid", c_rvalid, 1'b1);
      check("c_init_rdata",  c_rdata,  64'h0);
      c_cs = 1'b0;
      tick;
      check("c_idle_rvalid", c_rvalid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
